player_collision_detect: RTL
============================

// Module: player_collision_detect
// PURPOSE
//  Producer side of the player collision interface: scans the VGA pixel stream for overlap of the
//  player sprite with wall/column pixels, classifies which sprite edge was hit and issues
//  column_collision pulses with a HitEdgeCode to the player movement FSM.
//  Delivers at most MAX_HITS distinct non-zero codes per frame. Re-arms on every startOfFrame.
// PARAMETERS
//  OBJECT_SIZE  32  player sprite width/height in pixels (power of 2)
//  EDGE_BAND    4   pixels from a sprite border that count as that edge
//  MAX_HITS     2   distinct codes reported per frame (1..4)
// PORTS
//  clk             in   1  system clock
//  reset           in   1  asynchronous, active-high reset
//  startOfFrame    in   1  one-cycle pulse per frame
//  game_on         in   1  detection enabled when high
//  player_dr       in   1  player sprite drawing request for current pixel
//  wall_dr         in   1  wall/column drawing request for current pixel
//  offsetX         in   5  pixel X offset inside player sprite (0..OBJECT_SIZE-1)
//  offsetY         in   5  pixel Y offset inside player sprite
//  column_collision out 1  one-cycle hit pulse
//  HitEdgeCode     out  4  {LEFT,TOP,RIGHT,BOTTOM} = 1000/0100/0010/0001, corners OR'ed; valid with pulse, else 0
//  frame_edges     out  4  OR of all edge codes seen in previous frame, updated at startOfFrame
// BEHAVIOUR
//  Reset: column_collision=0, HitEdgeCode=0, frame_edges=0, state=IDLE_ST, all trackers cleared.
//  Classify (comb): TOP if offsetY<EDGE_BAND, BOTTOM if offsetY>=OBJECT_SIZE-EDGE_BAND,
//   LEFT/RIGHT likewise on offsetX. Interior pixel -> code 0 -> never reported.
//  hit = game_on & player_dr & wall_dr & (code!=0). Latency: pulse on cycle after hit pixel (1 clk).
//  States: IDLE_ST (game_on=0, no pulses) -> ARMED_ST on game_on; ARMED_ST -> COUNTING_ST on first
//   reported hit; COUNTING_ST -> FULL_ST when MAX_HITS codes reported; startOfFrame -> ARMED_ST
//   from ARMED/COUNTING/FULL; game_on=0 -> IDLE_ST from any state, pending output cleared.
//  Dedup: a code equal to any code already reported this frame is not reported again.
//  FULL_ST: hits ignored, accum still OR'ed into frame accumulator.
//  Frame accumulator ORs every hit code (reported or not); at startOfFrame copied to frame_edges
//   and cleared. startOfFrame coincident with hit: clear/copy first, hit counts as first of new frame.
//  Reset mid-frame: all outputs return to reset values asynchronously; next report needs game_on.
// CONFIGURATION
//  PLAYER_COLL_CORNER_SPLIT_EN defined: corner code (two bits set) emitted as two pulses on
//   consecutive cycles, vertical bit (TOP/BOTTOM) first, horizontal bit second; each half counts
//   toward MAX_HITS and dedup separately; a new hit arriving while second half pending is dropped
//   (still OR'ed into accumulator); second half suppressed if budget exhausted or game_on falls.
//  Not defined: corner code reported as one pulse with combined 4-bit code, counts as one hit.
// STRUCTURE
//  Package player_coll_pkg: edge constants TOP/RIGHT/LEFT/BOTTOM (4'b0100/0010/1000/0001),
//   coll_state_t enum {IDLE_ST,ARMED_ST,COUNTING_ST,FULL_ST}, edge_code_t typedef logic [3:0].
//  Sub-module player_edge_classify: combinational offsetX/offsetY -> edge_code_t, parameterised
//   by OBJECT_SIZE and EDGE_BAND. FSM, dedup table, split logic and accumulator stay in top.
// TESTING
//  1 game_on=1, overlap at offset (16,0) -> next cycle column_collision=1, HitEdgeCode=4'b0100.
//  2 Overlap at (0,0): macro off -> one pulse code 4'b1100; macro on -> 4'b0100 then 4'b1000.
//  3 Same frame hits (31,16),(31,17),(16,31),(0,16) with MAX_HITS=2 -> pulses 0010, 0001 only;
//    next startOfFrame -> frame_edges=4'b1011.
//  4 Overlap at interior (16,16) -> no pulse, frame_edges stays 0 after startOfFrame.
//  5 startOfFrame and hit (0,16) in same cycle after FULL_ST -> pulse 1000 reported.
//  6 game_on=0 or reset asserted mid-frame -> no pulses, outputs 0, state IDLE_ST.

Source files
------------

// File: rtl/player_coll_pkg.sv
// Shared edge codes, FSM state type and helpers for the player collision producer.
package player_coll_pkg;

    typedef logic [3:0] edge_code_t;

    localparam edge_code_t LEFT   = 4'b1000;
    localparam edge_code_t TOP    = 4'b0100;
    localparam edge_code_t RIGHT  = 4'b0010;
    localparam edge_code_t BOTTOM = 4'b0001;

    localparam edge_code_t VERT_MASK  = TOP | BOTTOM;
    localparam edge_code_t HORIZ_MASK = LEFT | RIGHT;

    typedef enum logic [1:0] {IDLE_ST, ARMED_ST, COUNTING_ST, FULL_ST} coll_state_t;

    function automatic logic is_corner(edge_code_t c);
        return (|(c & VERT_MASK)) && (|(c & HORIZ_MASK));
    endfunction

endpackage

// File: rtl/player_edge_classify.sv
// Maps a pixel offset inside the player sprite to the sprite edge(s) it lies on.
module player_edge_classify
    import player_coll_pkg::*;
#(
    parameter int OBJECT_SIZE = 32,
    parameter int EDGE_BAND   = 4
) (
    input  logic [4:0] offsetX,
    input  logic [4:0] offsetY,
    output edge_code_t code
);

    localparam logic [4:0] LO = 5'(EDGE_BAND);
    localparam logic [4:0] HI = 5'(OBJECT_SIZE - EDGE_BAND);

    // {LEFT, TOP, RIGHT, BOTTOM}; interior pixels produce 0
    assign code = {offsetX < LO, offsetY < LO, offsetX >= HI, offsetY >= HI};

endmodule

// File: rtl/player_collision_detect.sv
// Player/wall overlap detector: reports up to MAX_HITS distinct edge codes per frame.
// Optional PLAYER_COLL_CORNER_SPLIT_EN: corner hits issued as vertical then horizontal pulse.
module player_collision_detect
    import player_coll_pkg::*;
#(
    parameter int OBJECT_SIZE = 32,
    parameter int EDGE_BAND   = 4,
    parameter int MAX_HITS    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       game_on,
    input  logic       player_dr,
    input  logic       wall_dr,
    input  logic [4:0] offsetX,
    input  logic [4:0] offsetY,
    output logic       column_collision,
    output edge_code_t HitEdgeCode,
    output edge_code_t frame_edges
);

    localparam int CNT_W = 3;

    edge_code_t                  code;
    logic                        hit;
    coll_state_t                 state;
    logic [CNT_W-1:0]            cnt, base_cnt;
    logic [MAX_HITS-1:0][3:0]    tbl;
    edge_code_t                  accum;
    logic                        budget, emit;
    edge_code_t                  emit_code;
`ifdef PLAYER_COLL_CORNER_SPLIT_EN
    logic                        pend_vld, nxt_pend;
    edge_code_t                  pend_code, nxt_pend_code;
`endif

    player_edge_classify #(.OBJECT_SIZE(OBJECT_SIZE), .EDGE_BAND(EDGE_BAND)) u_classify (
        .offsetX(offsetX),
        .offsetY(offsetY),
        .code   (code)
    );

    assign hit = game_on & player_dr & wall_dr & (|code);

    function automatic logic seen(edge_code_t c, logic [CNT_W-1:0] n,
                                  logic [MAX_HITS-1:0][3:0] t);
        logic r;
        r = 1'b0;
        for (int i = 0; i < MAX_HITS; i++)
            if (i < int'(n) && t[i] == c) r = 1'b1;
        return r;
    endfunction

    // A start-of-frame clears the dedup table before the coincident hit is judged
    always_comb begin
        base_cnt  = startOfFrame ? '0 : cnt;
        budget    = base_cnt < CNT_W'(MAX_HITS);
        emit      = 1'b0;
        emit_code = '0;
`ifdef PLAYER_COLL_CORNER_SPLIT_EN
        nxt_pend      = 1'b0;
        nxt_pend_code = '0;
        if (pend_vld && !startOfFrame) begin
            if (budget && !seen(pend_code, base_cnt, tbl)) begin
                emit      = 1'b1;
                emit_code = pend_code;
            end
        end else if (hit && budget) begin
            if (is_corner(code)) begin
                if (!seen(code & VERT_MASK, base_cnt, tbl)) begin
                    emit          = 1'b1;
                    emit_code     = code & VERT_MASK;
                    nxt_pend      = !seen(code & HORIZ_MASK, base_cnt, tbl);
                    nxt_pend_code = code & HORIZ_MASK;
                end else if (!seen(code & HORIZ_MASK, base_cnt, tbl)) begin
                    emit      = 1'b1;
                    emit_code = code & HORIZ_MASK;
                end
            end else if (!seen(code, base_cnt, tbl)) begin
                emit      = 1'b1;
                emit_code = code;
            end
        end
`else
        if (hit && budget && !seen(code, base_cnt, tbl)) begin
            emit      = 1'b1;
            emit_code = code;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE_ST;
            column_collision <= 1'b0;
            HitEdgeCode      <= '0;
            frame_edges      <= '0;
            accum            <= '0;
            cnt              <= '0;
            tbl              <= '0;
`ifdef PLAYER_COLL_CORNER_SPLIT_EN
            pend_vld         <= 1'b0;
            pend_code        <= '0;
`endif
        end else if (!game_on) begin
            state            <= IDLE_ST;
            column_collision <= 1'b0;
            HitEdgeCode      <= '0;
            frame_edges      <= '0;
            accum            <= '0;
            cnt              <= '0;
            tbl              <= '0;
`ifdef PLAYER_COLL_CORNER_SPLIT_EN
            pend_vld         <= 1'b0;
            pend_code        <= '0;
`endif
        end else begin
            column_collision <= emit;
            HitEdgeCode      <= emit_code;
            accum            <= (startOfFrame ? '0 : accum) | (hit ? code : '0);
            if (startOfFrame) frame_edges <= accum;
            cnt <= base_cnt + CNT_W'(emit);
            for (int i = 0; i < MAX_HITS; i++)
                if (emit && base_cnt == CNT_W'(i)) tbl[i] <= emit_code;
            if (emit)
                state <= (base_cnt + 1'b1 == CNT_W'(MAX_HITS)) ? FULL_ST : COUNTING_ST;
            else if (startOfFrame || state == IDLE_ST)
                state <= ARMED_ST;
`ifdef PLAYER_COLL_CORNER_SPLIT_EN
            pend_vld  <= nxt_pend;
            pend_code <= nxt_pend_code;
`endif
        end
    end

endmodule
